// File: rtl/xsimbus_pkg.sv
// xsimbus_pkg: shared state encoding, bus direction constants and default device-ID width
package xsimbus_pkg;
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int DEV_ID_W_DEF = 5;
endpackage

// File: rtl/xsimbus_rr_arbiter_if.sv
// xsimbus_rr_arbiter_if: master-side requests and arbitrated device-side bus of the xSimBus arbiter
interface xsimbus_rr_arbiter_if #(
  parameter int MASTERS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEV_ID_W = xsimbus_pkg::DEV_ID_W_DEF
);
  localparam int MID_W = $clog2(MASTERS);
  localparam int NDEV = 2 ** DEV_ID_W;
  logic [MASTERS-1:0] req_in;
  logic [MASTERS-1:0] rw_in;
  logic [MASTERS*ADDR_W-1:0] addr_in;
  logic [MASTERS*DATA_W-1:0] wdata_in;
  logic [NDEV*DATA_W-1:0] dev_rdata_in;
  logic [MASTERS-1:0] grant_out;
  logic [MASTERS-1:0] hold_flag_out;
  logic [MID_W-1:0] master_id_out;
  logic [DEV_ID_W-1:0] device_id_out;
  logic [NDEV-1:0] dev_sel_out;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] wdata_out;
  logic rw_out;
  logic [DATA_W-1:0] rdata_out;
  logic busy_out;
  logic timeout_out;
  modport master (
    output req_in, rw_in, addr_in, wdata_in, dev_rdata_in,
    input grant_out, hold_flag_out, master_id_out, device_id_out, dev_sel_out,
    input addr_out, wdata_out, rw_out, rdata_out, busy_out, timeout_out
  );
  modport slave (
    input req_in, rw_in, addr_in, wdata_in, dev_rdata_in,
    output grant_out, hold_flag_out, master_id_out, device_id_out, dev_sel_out,
    output addr_out, wdata_out, rw_out, rdata_out, busy_out, timeout_out
  );
endinterface

// File: rtl/xsimbus_rr_picker.sv
// xsimbus_rr_picker: combinational rotating-priority picker, first requester at or after ptr wins
module xsimbus_rr_picker #(
  parameter int MASTERS = 4,
  parameter int MID_W = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req,
  input  logic [MID_W-1:0]   ptr,
  output logic [MASTERS-1:0] gnt,
  output logic [MID_W-1:0]   idx
);
  int best;
  always_comb begin
    gnt = '0;
    idx = '0;
    best = MASTERS;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && ((i + MASTERS - int'(ptr)) % MASTERS) < best) begin
        best = (i + MASTERS - int'(ptr)) % MASTERS;
        gnt = '0;
        gnt[i] = 1'b1;
        idx = MID_W'(i);
      end
    end
  end
endmodule

// File: rtl/xsimbus_rr_arbiter.sv
// xsimbus_rr_arbiter: round-robin xSimBus arbiter with address decode; XSIMBUS_TIMEOUT_EN adds forced release
module xsimbus_rr_arbiter #(
  parameter int MASTERS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEV_ID_W = xsimbus_pkg::DEV_ID_W_DEF,
  parameter int TIMEOUT = 256
) (
  input logic clk,
  input logic rst,
  xsimbus_rr_arbiter_if.slave bus
);
  import xsimbus_pkg::*;
  localparam int MID_W = $clog2(MASTERS);
  localparam int NDEV = 2 ** DEV_ID_W;
  state_t state;
  logic [MASTERS-1:0] grant, pick_gnt;
  logic [MID_W-1:0] mid, pick_idx, rr_ptr;
  logic busy, tmo, granted, force_rel;
  logic [ADDR_W-1:0] addr;
  logic [DEV_ID_W-1:0] dev_id;
  xsimbus_rr_picker #(.MASTERS(MASTERS), .MID_W(MID_W)) picker (
    .req(bus.req_in),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
`ifdef XSIMBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  // counter is zero outside OWN, so the limit can only match during an ownership
  always_ff @(posedge clk)
    cnt <= (rst || state != OWN || !bus.req_in[mid] || force_rel) ? '0 : cnt + 1'b1;
  assign force_rel = cnt == CW'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign force_rel = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      mid <= '0;
      rr_ptr <= '0;
      busy <= 1'b0;
      tmo <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: if (|bus.req_in) begin
          grant <= pick_gnt;
          mid <= pick_idx;
          busy <= 1'b1;
          state <= OWN;
        end
        OWN: if (!bus.req_in[mid] || force_rel) begin
          grant <= '0;
          mid <= '0;
          busy <= 1'b0;
          tmo <= force_rel && bus.req_in[mid];
          rr_ptr <= (mid == MID_W'(MASTERS - 1)) ? '0 : mid + 1'b1;
          state <= TURN;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign granted = |grant;
  assign addr = granted ? bus.addr_in[int'(mid)*ADDR_W +: ADDR_W] : '0;
  assign dev_id = addr[ADDR_W-1 -: DEV_ID_W];
  assign bus.grant_out = grant;
  assign bus.hold_flag_out = bus.req_in & ~grant;
  assign bus.master_id_out = mid;
  assign bus.device_id_out = dev_id;
  assign bus.dev_sel_out = granted ? NDEV'(1) << dev_id : '0;
  assign bus.addr_out = addr;
  assign bus.wdata_out = granted ? bus.wdata_in[int'(mid)*DATA_W +: DATA_W] : '0;
  assign bus.rw_out = granted ? bus.rw_in[mid] : RW_READ;
  assign bus.rdata_out = granted ? bus.dev_rdata_in[int'(dev_id)*DATA_W +: DATA_W] : '0;
  assign bus.busy_out = busy;
  assign bus.timeout_out = tmo;
endmodule

// File: tb/tb_xsimbus_rr_arbiter.sv
// tb_xsimbus_rr_arbiter: directed table-driven bench for the round-robin xSimBus arbiter
module tb_xsimbus_rr_arbiter;
  import xsimbus_pkg::*;
  typedef struct {
    bit rst;
    logic [3:0] req;
    logic [3:0] g;
    logic busy;
    logic [1:0] mid;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_n = 0;
  int total_n = 0;
  int ng = 0;
  int nt = 0;
  vec_t tbl[$];
  xsimbus_rr_arbiter_if #(.MASTERS(4), .ADDR_W(32), .DATA_W(32), .DEV_ID_W(5)) bus ();
  xsimbus_rr_arbiter #(.MASTERS(4), .ADDR_W(32), .DATA_W(32), .DEV_ID_W(5), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask
  task automatic step(input bit r, input logic [3:0] q);
    rst = r;
    bus.req_in = q;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input bit r, input logic [3:0] q, input logic [3:0] g, input logic b, input logic [1:0] m);
    tbl.push_back('{r, q, g, b, m});
  endtask
  initial begin
    bus.req_in = '0;
    bus.rw_in = 4'b1111;
    bus.addr_in = {32'h4000_0040, 32'h3000_0030, 32'h2000_0020, 32'h1000_0010};
    bus.wdata_in = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    for (int d = 0; d < 32; d++) bus.dev_rdata_in[d*32 +: 32] = 32'hD000_0000 + d;
    // single requester, rr_ptr advance, then a constant 4-way contention rotation
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0011, 4'b0010, 1, 1);
    add(0, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 1, 0);
    add(0, 4'b1110, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0010, 1, 1);
    add(0, 4'b1111, 4'b0010, 1, 1);
    add(0, 4'b1101, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0100, 1, 2);
    add(0, 4'b1111, 4'b0100, 1, 2);
    add(0, 4'b1011, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b1000, 1, 3);
    add(0, 4'b1111, 4'b1000, 1, 3);
    add(0, 4'b0111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 1, 0);
    add(0, 4'b1110, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req);
      chk($sformatf("grant[%0d]", i), bus.grant_out, tbl[i].g);
      chk($sformatf("busy[%0d]", i), bus.busy_out, tbl[i].busy);
      chk($sformatf("mid[%0d]", i), bus.master_id_out, tbl[i].mid);
      chk($sformatf("hold[%0d]", i), bus.hold_flag_out, tbl[i].req & ~tbl[i].g);
      if (i == 0) begin
        chk("rst_addr", bus.addr_out, 0);
        chk("rst_wdata", bus.wdata_out, 0);
        chk("rst_rw", bus.rw_out, 0);
        chk("rst_dev_sel", bus.dev_sel_out, 0);
        chk("rst_dev_id", bus.device_id_out, 0);
        chk("rst_rdata", bus.rdata_out, 0);
        chk("rst_timeout", bus.timeout_out, 0);
      end
    end
    // master 2 ownership moving across devices
    step(1, 4'b0000);
    bus.addr_in[64 +: 32] = 32'h0000_0010;
    bus.rw_in = 4'b0100;
    step(0, 4'b0100);
    chk("dec_grant", bus.grant_out, 4'b0100);
    chk("dec_mid", bus.master_id_out, 2);
    chk("dec_id0", bus.device_id_out, 0);
    chk("dec_sel0", bus.dev_sel_out, 32'h0000_0001);
    chk("dec_addr0", bus.addr_out, 32'h0000_0010);
    chk("dec_wdata", bus.wdata_out, 32'hCAFE_0002);
    chk("dec_rw", bus.rw_out, RW_WRITE);
    chk("dec_rdata0", bus.rdata_out, 32'hD000_0000);
    bus.addr_in[64 +: 32] = 32'hE800_0004;
    #1;
    chk("dec_id29", bus.device_id_out, 29);
    chk("dec_sel29", bus.dev_sel_out, 32'h2000_0000);
    chk("dec_addr29", bus.addr_out, 32'hE800_0004);
    chk("dec_rdata29", bus.rdata_out, 32'hD000_001D);
    bus.dev_rdata_in[29*32 +: 32] = 32'h1234_5678;
    #1;
    chk("dec_rdata_track", bus.rdata_out, 32'h1234_5678);
    step(0, 4'b0100);
    chk("dec_held", bus.grant_out, 4'b0100);
    step(0, 4'b0000);
    chk("rel_grant", bus.grant_out, 0);
    chk("rel_addr", bus.addr_out, 0);
    chk("rel_wdata", bus.wdata_out, 0);
    chk("rel_sel", bus.dev_sel_out, 0);
    chk("rel_rdata", bus.rdata_out, 0);
    chk("rel_rw", bus.rw_out, 0);
    // hold flags while master 1 owns, then reset mid-ownership
    bus.addr_in[32 +: 32] = 32'hF000_0040;
    step(1, 4'b0000);
    step(0, 4'b0010);
    chk("own1_grant", bus.grant_out, 4'b0010);
    step(0, 4'b1010);
    chk("own1_grant2", bus.grant_out, 4'b0010);
    chk("own1_hold", bus.hold_flag_out, 4'b1000);
    chk("own1_addr", bus.addr_out, 32'hF000_0040);
    bus.req_in = 4'b0010;
    #1;
    chk("hold_drop", bus.hold_flag_out, 4'b0000);
    bus.req_in = 4'b1010;
    rst = 1'b1;
    #1;
    chk("hold_in_rst", bus.hold_flag_out, 4'b1000);
    @(posedge clk);
    #1;
    chk("mid_rst_grant", bus.grant_out, 0);
    chk("mid_rst_busy", bus.busy_out, 0);
    chk("mid_rst_hold", bus.hold_flag_out, 4'b1010);
    chk("mid_rst_mid", bus.master_id_out, 0);
    chk("mid_rst_addr", bus.addr_out, 0);
    chk("mid_rst_sel", bus.dev_sel_out, 0);
    chk("mid_rst_rdata", bus.rdata_out, 0);
    chk("mid_rst_tmo", bus.timeout_out, 0);
    // master 0 never lets go
    step(1, 4'b0000);
`ifdef XSIMBUS_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step(0, 4'b0001);
      chk($sformatf("to_own[%0d]", k), bus.grant_out, 4'b0001);
      chk($sformatf("to_pulse_lo[%0d]", k), bus.timeout_out, 0);
    end
    step(0, 4'b0001);
    chk("to_release", bus.grant_out, 0);
    chk("to_pulse", bus.timeout_out, 1);
    chk("to_busy", bus.busy_out, 0);
    step(0, 4'b0001);
    chk("to_idle", bus.grant_out, 0);
    chk("to_pulse_end", bus.timeout_out, 0);
    step(0, 4'b0001);
    chk("to_regrant", bus.grant_out, 4'b0001);
`else
    for (int k = 0; k < 1000; k++) begin
      step(0, 4'b0001);
      ng += int'(bus.grant_out === 4'b0001);
      nt += int'(bus.timeout_out !== 1'b0);
    end
    chk("hold_1000", ng, 1000);
    chk("no_timeout", nt, 0);
`endif
    step(0, 4'b0000);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
